multiport_regfile: RTL and testbench

Parametrised register file with configurable width and depth, N combinational read ports and two prioritised write ports. Adds optional hardwired-zero register 0, write-to-read bypass, and a per-register pending scoreboard with a registered pending count. It sits between decode/issue (allocation, operand read) and writeback (two result buses).

---
 rtl/multiport_regfile_pkg.sv | 13 +
 rtl/multiport_regfile_read_port.sv | 61 ++++++
 rtl/multiport_regfile.sv | 121 ++++++++++++
 tb/tb_multiport_regfile.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/multiport_regfile_pkg.sv
// Shared defaults and option constants for the register file and the
// issue/writeback blocks that will sit around it.
package multiport_regfile_pkg;

  localparam int unsigned RF_DATA_WIDTH_DEF = 64;
  localparam int unsigned RF_NUM_REGS_DEF   = 32;
  localparam int unsigned RF_NUM_RD_DEF     = 2;

  // Values for the ZERO_REG / BYPASS options.
  localparam bit RF_OPT_OFF = 1'b0;
  localparam bit RF_OPT_ON  = 1'b1;

endpackage : multiport_regfile_pkg

// File: rtl/multiport_regfile_read_port.sv
// One combinational read lane: stored value and pending bit, overridden by
// same-cycle write forwarding, masked for register 0 and unmapped addresses.
module regfile_read_port
  import multiport_regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH_DEF,
  parameter int unsigned NUM_REGS   = RF_NUM_REGS_DEF,
  parameter int unsigned ADDR_WIDTH = $clog2(NUM_REGS),
  parameter bit          ZERO_REG   = RF_OPT_ON,
  parameter bit          BYPASS     = RF_OPT_ON
) (
  input  logic                           rst_i,
  input  logic [ADDR_WIDTH-1:0]          addr_i,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] regs_i,
  input  logic [NUM_REGS-1:0]            pend_i,
  input  logic                           wr0_en_i,
  input  logic [ADDR_WIDTH-1:0]          wr0_addr_i,
  input  logic [DATA_WIDTH-1:0]          wr0_data_i,
  input  logic                           wr1_en_i,
  input  logic [ADDR_WIDTH-1:0]          wr1_addr_i,
  input  logic [DATA_WIDTH-1:0]          wr1_data_i,
  input  logic                           alloc_en_i,
  input  logic [ADDR_WIDTH-1:0]          alloc_addr_i,
  output logic [DATA_WIDTH-1:0]          data_o,
  output logic                           pend_o
);

  logic blocked;
  logic fwd_ok;
  logic hit0;
  logic hit1;
  logic alloc_hit;

  // NOTE: every signal written here gets a value before any branch, so no
  // path through the block can leave one holding its old value (a latch).
  always_comb begin
    data_o    = '0;
    pend_o    = 1'b0;
    blocked   = (int'(addr_i) >= int'(NUM_REGS)) ||
                ((ZERO_REG != RF_OPT_OFF) && (addr_i == '0));
    // Forwarding is suppressed while in reset so reads stay at zero.
    fwd_ok    = (BYPASS != RF_OPT_OFF) && !rst_i;
    hit0      = fwd_ok && wr0_en_i && (wr0_addr_i == addr_i);
    hit1      = fwd_ok && wr1_en_i && (wr1_addr_i == addr_i);
    alloc_hit = !rst_i && alloc_en_i && (alloc_addr_i == addr_i);

    if (!blocked) begin
      if (hit1) begin
        data_o = wr1_data_i;
        pend_o = alloc_hit;
      end else if (hit0) begin
        data_o = wr0_data_i;
        pend_o = alloc_hit;
      end else begin
        data_o = regs_i[int'(addr_i)*DATA_WIDTH +: DATA_WIDTH];
        pend_o = pend_i[addr_i];
      end
    end
  end

endmodule : regfile_read_port

// File: rtl/multiport_regfile.sv
// Register file with N read lanes, two prioritised write ports (wr1 wins),
// a per-register pending scoreboard and a registered pending count.
module multiport_regfile
  import multiport_regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH_DEF,
  parameter int unsigned NUM_REGS   = RF_NUM_REGS_DEF,
  parameter int unsigned ADDR_WIDTH = $clog2(NUM_REGS),
  parameter int unsigned NUM_RD     = RF_NUM_RD_DEF,
  parameter bit          ZERO_REG   = RF_OPT_ON,
  parameter bit          BYPASS     = RF_OPT_ON
) (
  input  logic                           Clk,
  input  logic                           Rst,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_Addr,
  output logic [NUM_RD*DATA_WIDTH-1:0]   rd_Data,
  output logic [NUM_RD-1:0]              rd_Pending,
  input  logic                           wr0_En,
  input  logic [ADDR_WIDTH-1:0]          wr0_Addr,
  input  logic [DATA_WIDTH-1:0]          wr0_Data,
  input  logic                           wr1_En,
  input  logic [ADDR_WIDTH-1:0]          wr1_Addr,
  input  logic [DATA_WIDTH-1:0]          wr1_Data,
  input  logic                           alloc_En,
  input  logic [ADDR_WIDTH-1:0]          alloc_Addr,
  output logic [$clog2(NUM_REGS+1)-1:0]  pend_Count
);

  localparam int unsigned CNT_WIDTH = $clog2(NUM_REGS + 1);

  logic [DATA_WIDTH-1:0]          regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]          regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]            pend_q;
  logic [NUM_REGS-1:0]            pend_d;
  logic [CNT_WIDTH-1:0]           cnt_q;
  logic [CNT_WIDTH-1:0]           cnt_d;
  logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat;
  logic                           wr0_ok;
  logic                           wr1_ok;
  logic                           alloc_ok;

  // A target is writable when it is mapped and is not the hardwired zero.
  function automatic logic target_ok(input logic [ADDR_WIDTH-1:0] a);
    return (int'(a) < int'(NUM_REGS)) &&
           !((ZERO_REG != RF_OPT_OFF) && (a == '0));
  endfunction

  assign wr0_ok   = wr0_En   && target_ok(wr0_Addr);
  assign wr1_ok   = wr1_En   && target_ok(wr1_Addr);
  assign alloc_ok = alloc_En && target_ok(alloc_Addr);

  // Applied in priority order: wr0, then wr1 over it, then alloc over both.
  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    if (wr0_ok) begin
      regs_d[wr0_Addr] = wr0_Data;
      pend_d[wr0_Addr] = 1'b0;
    end
    if (wr1_ok) begin
      regs_d[wr1_Addr] = wr1_Data;
      pend_d[wr1_Addr] = 1'b0;
    end
    if (alloc_ok) begin
      pend_d[alloc_Addr] = 1'b1;
    end
    cnt_d = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      cnt_d = cnt_d + CNT_WIDTH'(pend_d[i]);
    end
  end

  // NOTE: the storage array is reset along with the scoreboard because every
  // register must read zero straight out of reset; all flops here take <=
  // so each one samples the pre-edge value of the others.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= '0;
      end
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pend_Count = cnt_q;

  for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_flat
    assign regs_flat[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end

  for (genvar k = 0; k < int'(NUM_RD); k++) begin : g_rd
    regfile_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_REGS   (NUM_REGS),
      .ADDR_WIDTH (ADDR_WIDTH),
      .ZERO_REG   (ZERO_REG),
      .BYPASS     (BYPASS)
    ) u_rd (
      .rst_i        (Rst),
      .addr_i       (rd_Addr[k*ADDR_WIDTH +: ADDR_WIDTH]),
      .regs_i       (regs_flat),
      .pend_i       (pend_q),
      .wr0_en_i     (wr0_En),
      .wr0_addr_i   (wr0_Addr),
      .wr0_data_i   (wr0_Data),
      .wr1_en_i     (wr1_En),
      .wr1_addr_i   (wr1_Addr),
      .wr1_data_i   (wr1_Data),
      .alloc_en_i   (alloc_En),
      .alloc_addr_i (alloc_Addr),
      .data_o       (rd_Data[k*DATA_WIDTH +: DATA_WIDTH]),
      .pend_o       (rd_Pending[k])
    );
  end

endmodule : multiport_regfile

// File: tb/tb_multiport_regfile.sv
// Checks a bypassing and a non-bypassing register file against an array
// model every cycle, with directed cases pinned by literal expectations.
module tb_multiport_regfile;

  localparam int DW  = 64;
  localparam int NR  = 32;
  localparam int AW  = 5;
  localparam int NRD = 2;
  localparam int CW  = 6;

  logic           Clk = 1'b0;
  logic           Rst = 1'b1;
  logic [NRD*AW-1:0] rd_Addr;
  logic [NRD*DW-1:0] rd_Data, rd_Data_nb;
  logic [NRD-1:0]    rd_Pending, rd_Pending_nb;
  logic           wr0_En, wr1_En, alloc_En;
  logic [AW-1:0]  wr0_Addr, wr1_Addr, alloc_Addr;
  logic [DW-1:0]  wr0_Data, wr1_Data;
  logic [CW-1:0]  pend_Count, pend_Count_nb;

  int n_checks = 0;
  int n_fail   = 0;

  multiport_regfile #(.DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_RD(NRD),
                      .ZERO_REG(1), .BYPASS(1)) u_dut (
    .Clk(Clk), .Rst(Rst), .rd_Addr(rd_Addr), .rd_Data(rd_Data),
    .rd_Pending(rd_Pending), .wr0_En(wr0_En), .wr0_Addr(wr0_Addr),
    .wr0_Data(wr0_Data), .wr1_En(wr1_En), .wr1_Addr(wr1_Addr),
    .wr1_Data(wr1_Data), .alloc_En(alloc_En), .alloc_Addr(alloc_Addr),
    .pend_Count(pend_Count)
  );

  multiport_regfile #(.DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_RD(NRD),
                      .ZERO_REG(1), .BYPASS(0)) u_dut_nb (
    .Clk(Clk), .Rst(Rst), .rd_Addr(rd_Addr), .rd_Data(rd_Data_nb),
    .rd_Pending(rd_Pending_nb), .wr0_En(wr0_En), .wr0_Addr(wr0_Addr),
    .wr0_Data(wr0_Data), .wr1_En(wr1_En), .wr1_Addr(wr1_Addr),
    .wr1_Data(wr1_Data), .alloc_En(alloc_En), .alloc_Addr(alloc_Addr),
    .pend_Count(pend_Count_nb)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // Reference model: plain arrays updated by the architectural rules.
  logic [DW-1:0] m_regs [NR];
  bit            m_pend [NR];

  always @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < NR; i++) begin
        m_regs[i] = '0;
        m_pend[i] = 1'b0;
      end
    end else begin
      if (wr0_En && wr0_Addr != 0) begin
        m_regs[wr0_Addr] = wr0_Data;
        m_pend[wr0_Addr] = 1'b0;
      end
      if (wr1_En && wr1_Addr != 0) begin
        m_regs[wr1_Addr] = wr1_Data;
        m_pend[wr1_Addr] = 1'b0;
      end
      if (alloc_En && alloc_Addr != 0) m_pend[alloc_Addr] = 1'b1;
    end
  end

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < NR; i++) c += int'(m_pend[i]);
    return c;
  endfunction

  function automatic void exp_rd(input logic [AW-1:0] a, input bit byp,
                                 output logic [DW-1:0] d, output bit p);
    if (a == 0) begin
      d = '0; p = 1'b0;
    end else if (byp && !Rst && wr1_En && wr1_Addr == a) begin
      d = wr1_Data; p = alloc_En && alloc_Addr == a;
    end else if (byp && !Rst && wr0_En && wr0_Addr == a) begin
      d = wr0_Data; p = alloc_En && alloc_Addr == a;
    end else begin
      d = m_regs[a]; p = m_pend[a];
    end
  endfunction

  always @(negedge Clk) begin
    logic [DW-1:0] ed;
    bit            ep;
    check("pend_count",    64'(pend_Count),    64'(m_count()));
    check("pend_count_nb", 64'(pend_Count_nb), 64'(m_count()));
    for (int k = 0; k < NRD; k++) begin
      exp_rd(rd_Addr[k*AW +: AW], 1'b1, ed, ep);
      check("rd_data",    rd_Data[k*DW +: DW], ed);
      check("rd_pend",    64'(rd_Pending[k]), 64'(ep));
      exp_rd(rd_Addr[k*AW +: AW], 1'b0, ed, ep);
      check("rd_data_nb", rd_Data_nb[k*DW +: DW], ed);
      check("rd_pend_nb", 64'(rd_Pending_nb[k]), 64'(ep));
    end
  end

  task automatic idle();
    wr0_En = 1'b0; wr0_Addr = '0; wr0_Data = '0;
    wr1_En = 1'b0; wr1_Addr = '0; wr1_Data = '0;
    alloc_En = 1'b0; alloc_Addr = '0;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_Addr = {a1, a0};
  endtask

  initial begin
    idle();
    set_rd('0, '0);
    repeat (2) step();
    @(negedge Clk);
    check("reset_count", 64'(pend_Count), 64'd0);
    step();
    Rst = 1'b0;

    for (int a = 0; a < NR; a++) begin
      set_rd(AW'(a), AW'(NR - 1 - a));
      @(negedge Clk);
      check("sweep_data", rd_Data[DW-1:0], 64'd0);
      step();
    end

    // Alloc then clear register 5.
    alloc_En = 1'b1; alloc_Addr = 5; set_rd(5, 5);
    step(); idle();
    @(negedge Clk);
    check("alloc5_pend",  64'(rd_Pending[0]), 64'd1);
    check("alloc5_count", 64'(pend_Count), 64'd1);
    step();
    wr0_En = 1'b1; wr0_Addr = 5; wr0_Data = 64'hDEAD;
    step(); idle();
    @(negedge Clk);
    check("wr5_data",  rd_Data[DW-1:0], 64'hDEAD);
    check("wr5_pend",  64'(rd_Pending[0]), 64'd0);
    check("wr5_count", 64'(pend_Count), 64'd0);
    step();

    // Dual write to the same register: wr1 wins, forwarded the same cycle.
    wr0_En = 1'b1; wr0_Addr = 7; wr0_Data = 64'h11;
    wr1_En = 1'b1; wr1_Addr = 7; wr1_Data = 64'h22;
    set_rd(7, 7);
    @(negedge Clk);
    check("dual_bypass",    rd_Data[DW-1:0], 64'h22);
    check("dual_nb_old",    rd_Data_nb[DW-1:0], 64'h0);
    step(); idle();
    @(negedge Clk);
    check("dual_stored",    rd_Data[DW-1:0], 64'h22);
    check("dual_stored_nb", rd_Data_nb[DW-1:0], 64'h22);
    step();

    // Alloc and write the same register: data lands, pending stays set.
    alloc_En = 1'b1; alloc_Addr = 9;
    wr1_En = 1'b1; wr1_Addr = 9; wr1_Data = 64'h33;
    set_rd(9, 9);
    step(); idle();
    @(negedge Clk);
    check("aw9_data",  rd_Data[DW-1:0], 64'h33);
    check("aw9_pend",  64'(rd_Pending[0]), 64'd1);
    check("aw9_count", 64'(pend_Count), 64'd1);
    step();

    // Register 0 ignores writes and allocs.
    wr0_En = 1'b1; wr0_Addr = 0; wr0_Data = 64'hFF;
    alloc_En = 1'b1; alloc_Addr = 0;
    set_rd(0, 0);
    @(negedge Clk);
    check("zero_data", rd_Data[DW-1:0], 64'h0);
    check("zero_pend", 64'(rd_Pending[0]), 64'd0);
    step(); idle();
    @(negedge Clk);
    check("zero_count", 64'(pend_Count), 64'd1);
    step();

    // Without bypass the new value shows only after the edge.
    wr0_En = 1'b1; wr0_Addr = 3; wr0_Data = 64'h44;
    set_rd(3, 3);
    @(negedge Clk);
    check("nb_same_cycle", rd_Data_nb[DW-1:0], 64'h0);
    check("byp_same_cycle", rd_Data[DW-1:0], 64'h44);
    step(); idle();
    @(negedge Clk);
    check("nb_next_cycle", rd_Data_nb[DW-1:0], 64'h44);
    step();

    // Alloc 1..15 (9 already pending), then reset asynchronously mid-cycle.
    for (int i = 1; i < NR; i++) begin
      alloc_En = 1'b1; alloc_Addr = AW'(i);
      if (i == 16) begin
        check("seq_count", 64'(pend_Count), 64'd15);
        wr0_En = 1'b1; wr0_Addr = 2; wr0_Data = 64'h55;
        set_rd(1, 2);
        #2 Rst = 1'b1;
        #1;
        check("async_count", 64'(pend_Count), 64'd0);
        check("async_pend",  64'(rd_Pending), 64'd0);
        check("async_data",  rd_Data[DW-1:0], 64'd0);
        step();
        step();
        Rst = 1'b0;
        idle();
        break;
      end
      step();
    end
    set_rd(2, 1);
    @(negedge Clk);
    check("rst_edge_write_lost", rd_Data[DW-1:0], 64'd0);
    check("rst_edge_count",      64'(pend_Count), 64'd0);
    step();

    // Randomised traffic, biased toward colliding addresses.
    repeat (800) begin
      wr0_En   = 1'($urandom_range(0, 1));
      wr1_En   = 1'($urandom_range(0, 1));
      alloc_En = 1'($urandom_range(0, 1));
      wr0_Addr   = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      wr1_Addr   = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      alloc_Addr = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      wr0_Data = {$urandom, $urandom};
      wr1_Data = {$urandom, $urandom};
      set_rd(($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom),
             AW'($urandom));
      Rst = ($urandom_range(0, 99) == 0);
      step();
    end
    Rst = 1'b0;
    idle();
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_multiport_regfile
